// File: rtl/rtc_apb_mt.sv
// rtc_apb_mt: APB3 RTC (prescaler, time-of-day with masked alarm, N second timers); zero-wait, pready=1.
// Write commits in the access-phase edge, irq_o one cycle behind EVT; optional pslverr under RTC_APB_PSLVERR_EN.
module rtc_apb_mt #(
  parameter int                 APB_ADDR_W = 12,
  parameter int                 N_TIMERS   = 2,
  parameter int                 TIMER_W    = 17,
  parameter int                 PRESC_W    = 16,
  parameter logic [PRESC_W-1:0] PRESC_RST  = 16'd32767
) (
  input  logic                  pclk,
  input  logic                  prst,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [APB_ADDR_W-1:0] paddr,
  input  logic [31:0]           pwdata,
  output logic [31:0]           prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic                  irq_o,
  output logic                  sec_tick_o,
  output logic                  day_tick_o
);

  typedef struct packed {
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
  } tod_t;

  localparam int EW = N_TIMERS + 1;

  logic               rtc_en;
  logic [PRESC_W-1:0] presc, pcnt;
  tod_t               tod, al_tod, tod_inc, tod_nxt, tod_wr;
  logic               al_en;
  logic [2:0]         al_mask;
  logic [EW-1:0]      evt, irq_en;
  logic               t_en [N_TIMERS];
  logic               t_rt [N_TIMERS];
  logic [TIMER_W-1:0] t_cmp [N_TIMERS];
  logic [TIMER_W-1:0] t_val [N_TIMERS];
  logic [TIMER_W:0]   t_top [N_TIMERS];
  logic [N_TIMERS-1:0] t_hit, wr_tctrl;

  logic [5:0]  off;
  logic        acc, mapped, is_tval, bad, wr_ok;
  logic        wr_ctrl, wr_presc, wr_time, wr_alarm, wr_evt, wr_irqen;
  logic        tick, tod_wrap, tod_chg, day_hit, al_hit;
  logic [31:0] rd;
  logic        unused_bits;

  assign unused_bits = ^{paddr[APB_ADDR_W-1:8], pwdata};
  assign pready      = 1'b1;
  assign off         = paddr[7:2];
  assign acc         = psel & penable;

  always_comb begin
    mapped  = (off <= 6'd5);
    is_tval = 1'b0;
    for (int i = 0; i < N_TIMERS; i++) begin
      if (off == 6'(8 + 2*i)) mapped = 1'b1;
      if (off == 6'(9 + 2*i)) begin
        mapped  = 1'b1;
        is_tval = 1'b1;
      end
    end
  end

  // Errored accesses (or silently ignored ones) never reach any register.
  assign bad      = ~mapped | (pwrite & is_tval) | (paddr[1:0] != 2'b00);
  assign wr_ok    = acc & pwrite & ~bad;
  assign wr_ctrl  = wr_ok & (off == 6'd0);
  assign wr_presc = wr_ok & (off == 6'd1);
  assign wr_time  = wr_ok & (off == 6'd2);
  assign wr_alarm = wr_ok & (off == 6'd3);
  assign wr_evt   = wr_ok & (off == 6'd4);
  assign wr_irqen = wr_ok & (off == 6'd5);

`ifdef RTC_APB_PSLVERR_EN
  assign pslverr = acc & bad;
`else
  assign pslverr = 1'b0;
`endif

  assign tick = rtc_en & (pcnt == presc);

  assign tod_wr.hour = (pwdata[20:16] > 5'd23) ? 5'd23 : pwdata[20:16];
  assign tod_wr.min  = (pwdata[13:8]  > 6'd59) ? 6'd59 : pwdata[13:8];
  assign tod_wr.sec  = (pwdata[5:0]   > 6'd59) ? 6'd59 : pwdata[5:0];

  always_comb begin
    tod_inc  = tod;
    tod_wrap = 1'b0;
    if (tod.sec == 6'd59) begin
      tod_inc.sec = '0;
      if (tod.min == 6'd59) begin
        tod_inc.min = '0;
        if (tod.hour == 5'd23) begin
          tod_inc.hour = '0;
          tod_wrap     = 1'b1;
        end else begin
          tod_inc.hour = tod.hour + 5'd1;
        end
      end else begin
        tod_inc.min = tod.min + 6'd1;
      end
    end else begin
      tod_inc.sec = tod.sec + 6'd1;
    end
  end

  // A TIME write overrides a coincident tick, so that tick never advances the clock.
  assign tod_nxt = wr_time ? tod_wr : (tick ? tod_inc : tod);
  assign tod_chg = wr_time | tick;
  assign day_hit = tick & ~wr_time & tod_wrap;

  assign al_hit = tod_chg & al_en & (|al_mask)
                & (~al_mask[2] | (tod_nxt.hour == al_tod.hour))
                & (~al_mask[1] | (tod_nxt.min  == al_tod.min))
                & (~al_mask[0] | (tod_nxt.sec  == al_tod.sec));

  // cmp == 0 is treated as 2^TIMER_W so the counter runs its full range.
  always_comb begin
    for (int i = 0; i < N_TIMERS; i++) begin
      wr_tctrl[i] = wr_ok & (off == 6'(8 + 2*i));
      t_top[i]    = (t_cmp[i] == '0) ? {1'b1, {TIMER_W{1'b0}}} : {1'b0, t_cmp[i]};
      t_hit[i]    = tick & t_en[i] & ~wr_tctrl[i]
                  & (({1'b0, t_val[i]} + 1'b1) == t_top[i]);
    end
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      rtc_en     <= 1'b0;
      presc      <= PRESC_RST;
      pcnt       <= '0;
      tod        <= '0;
      al_en      <= 1'b0;
      al_mask    <= '0;
      al_tod     <= '0;
      evt        <= '0;
      irq_en     <= '0;
      irq_o      <= 1'b0;
      sec_tick_o <= 1'b0;
      day_tick_o <= 1'b0;
      for (int i = 0; i < N_TIMERS; i++) begin
        t_en[i]  <= 1'b0;
        t_rt[i]  <= 1'b0;
        t_cmp[i] <= '0;
        t_val[i] <= '0;
      end
    end else begin
      if (wr_ctrl)  rtc_en <= pwdata[0];
      if (wr_presc) presc  <= pwdata[PRESC_W-1:0];
      if (wr_presc | wr_time | tick) pcnt <= '0;
      else if (rtc_en)               pcnt <= pcnt + 1'b1;
      sec_tick_o <= tick;
      day_tick_o <= day_hit;
      tod        <= tod_nxt;
      if (wr_alarm) begin
        al_en       <= pwdata[31];
        al_mask     <= pwdata[26:24];
        al_tod.hour <= pwdata[20:16];
        al_tod.min  <= pwdata[13:8];
        al_tod.sec  <= pwdata[5:0];
      end
      if (wr_irqen) irq_en <= pwdata[EW-1:0];
      // Hardware set is OR-ed in after the w1c mask, so a coincident set survives.
      evt   <= (evt & ~(wr_evt ? pwdata[EW-1:0] : {EW{1'b0}})) | {t_hit, al_hit};
      irq_o <= |(evt & irq_en);
      for (int i = 0; i < N_TIMERS; i++) begin
        if (wr_tctrl[i]) begin
          t_en[i]  <= pwdata[31];
          t_rt[i]  <= pwdata[30];
          t_cmp[i] <= pwdata[TIMER_W-1:0];
          t_val[i] <= '0;
        end else if (tick & t_en[i]) begin
          if (t_hit[i]) begin
            if (t_rt[i]) begin
              t_val[i] <= '0;
            end else begin
              t_val[i] <= t_cmp[i];
              t_en[i]  <= 1'b0;
            end
          end else begin
            t_val[i] <= t_val[i] + 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    rd = '0;
    case (off)
      6'd0: rd[0] = rtc_en;
      6'd1: rd[PRESC_W-1:0] = presc;
      6'd2: rd = {11'b0, tod.hour, 2'b0, tod.min, 2'b0, tod.sec};
      6'd3: rd = {al_en, 4'b0, al_mask, 3'b0, al_tod.hour, 2'b0, al_tod.min, 2'b0, al_tod.sec};
      6'd4: rd[EW-1:0] = evt;
      6'd5: rd[EW-1:0] = irq_en;
      default: ;
    endcase
    for (int i = 0; i < N_TIMERS; i++) begin
      if (off == 6'(8 + 2*i)) begin
        rd[31]          = t_en[i];
        rd[30]          = t_rt[i];
        rd[TIMER_W-1:0] = t_cmp[i];
      end else if (off == 6'(9 + 2*i)) begin
        rd[TIMER_W-1:0] = t_val[i];
      end
    end
  end

  assign prdata = (acc & ~pwrite & ~bad) ? rd : 32'h0;

endmodule

// File: tb/tb_rtc_apb_mt.sv
// Bench for rtc_apb_mt: APB read expectations go through a queue, checked when the access phase is seen.
// Tick-timed sequences rely on the 2-cycle back-to-back APB tasks below.
`timescale 1ns/1ps
module tb_rtc_apb_mt;

  logic        pclk = 1'b0;
  logic        prst, psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr, irq_o, sec_tick_o, day_tick_o;

  int          checks = 0;
  int          errors = 0;
  string       tq[$];
  logic [31:0] eq[$];
  logic        last_err;
  logic        found;
  int          ncyc;

`ifdef RTC_APB_PSLVERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  rtc_apb_mt dut (
    .pclk(pclk), .prst(prst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .irq_o(irq_o), .sec_tick_o(sec_tick_o), .day_tick_o(day_tick_o)
  );

  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] addr_of(input int o);
    return 12'(o * 4);
  endfunction

  // Read access phases pop the scoreboard.
  always @(negedge pclk) begin
    if (psel && penable && !pwrite) begin
      if (eq.size() == 0) chk("rd_unexpected", 32'(eq.size()), 32'd1);
      else chk(tq.pop_front(), prdata, eq.pop_front());
    end
  end

  // All APB tasks start and end 1ns after a rising edge and take exactly two cycles.
  task automatic apb_wr(input logic [11:0] a, input logic [31:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge pclk); #1 penable = 1'b1;
    @(negedge pclk); last_err = pslverr;
    @(posedge pclk); #1 psel = 1'b0; penable = 1'b0;
  endtask

  task automatic apb_rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    tq.push_back(tag); eq.push_back(exp);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(posedge pclk); #1 penable = 1'b1;
    @(negedge pclk); last_err = pslverr;
    @(posedge pclk); #1 psel = 1'b0; penable = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  initial begin
    prst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    repeat (3) @(posedge pclk);
    #1 prst = 1'b0;

    chk("irq_rst", irq_o, 0);
    chk("sec_tick_rst", sec_tick_o, 0);
    chk("day_tick_rst", day_tick_o, 0);
    chk("pready", pready, 1);
    apb_rd("ctrl_rst",   addr_of(0),  32'h0);
    apb_rd("presc_rst",  addr_of(1),  32'h0000_7FFF);
    apb_rd("time_rst",   addr_of(2),  32'h0);
    apb_rd("alarm_rst",  addr_of(3),  32'h0);
    apb_rd("evt_rst",    addr_of(4),  32'h0);
    apb_rd("irqen_rst",  addr_of(5),  32'h0);
    apb_rd("unmap6_rst", addr_of(6),  32'h0);
    apb_rd("tctrl0_rst", addr_of(8),  32'h0);
    apb_rd("tval0_rst",  addr_of(9),  32'h0);
    apb_rd("tctrl1_rst", addr_of(10), 32'h0);
    apb_rd("tval1_rst",  addr_of(11), 32'h0);

    // Day rollover: PRESC=3 gives a tick 4 cycles after enable.
    apb_wr(addr_of(1), 32'd3);
    apb_wr(addr_of(2), 32'h0017_3B3B);
    apb_rd("time_2359", addr_of(2), 32'h0017_3B3B);
    apb_wr(addr_of(0), 32'd1);
    found = 1'b0; ncyc = 0;
    for (int c = 1; c <= 20 && !found; c++) begin
      @(posedge pclk); #1;
      if (sec_tick_o) begin found = 1'b1; ncyc = c; end
    end
    chk("tick_seen", found, 1);
    chk("tick_latency", ncyc, 4);
    chk("day_tick", day_tick_o, 1);
    @(posedge pclk); #1;
    chk("tick_one_cycle", sec_tick_o, 0);
    apb_wr(addr_of(0), 32'd0);
    apb_rd("time_wrap", addr_of(2), 32'h0);

    // Retrigger timer 0, cmp=5, PRESC=1: each back-to-back read lands one tick later.
    apb_wr(addr_of(1), 32'd1);
    apb_wr(addr_of(4), 32'hFF);
    apb_wr(addr_of(5), 32'd2);
    apb_wr(addr_of(8), 32'hC000_0005);
    apb_wr(addr_of(0), 32'd1);
    for (int k = 0; k < 7; k++) begin
      apb_rd($sformatf("tval0_seq%0d", k), addr_of(9), 32'(k % 5));
      if (k == 4) chk("irq_lags_evt", irq_o, 0);
      if (k == 5) chk("irq_set", irq_o, 1);
    end
    apb_wr(addr_of(4), 32'd2);
    apb_rd("evt_w1c", addr_of(4), 32'h0);
    apb_wr(addr_of(4), 32'd2);
    apb_rd("evt_set_beats_w1c", addr_of(4), 32'h2);
    apb_wr(addr_of(0), 32'd0);
    apb_wr(addr_of(8), 32'h0);
    apb_wr(addr_of(4), 32'hFF);

    // One-shot timer 1, cmp=3, PRESC=0.
    apb_wr(addr_of(1), 32'd0);
    apb_wr(addr_of(10), 32'h8000_0003);
    apb_wr(addr_of(0), 32'd1);
    idle(8);
    apb_wr(addr_of(0), 32'd0);
    apb_rd("tval1_hold",   addr_of(11), 32'd3);
    apb_rd("tctrl1_autoclr", addr_of(10), 32'd3);
    apb_rd("evt_t1",       addr_of(4),  32'h4);
    apb_wr(addr_of(4), 32'h4);
    apb_wr(addr_of(0), 32'd1);
    idle(4);
    apb_wr(addr_of(0), 32'd0);
    apb_rd("evt_oneshot_once", addr_of(4), 32'h0);

    // Alarm on seconds only; each enable/disable write pair yields exactly two ticks.
    apb_wr(addr_of(3), 32'h8100_000A);
    apb_wr(addr_of(2), 32'h0003_0705);
    for (int p = 0; p < 3; p++) begin
      apb_wr(addr_of(0), 32'd1);
      apb_wr(addr_of(0), 32'd0);
      apb_rd($sformatf("evt_alarm_p%0d", p), addr_of(4), (p == 2) ? 32'h1 : 32'h0);
    end
    apb_rd("time_after_alarm", addr_of(2), 32'h0003_070B);
    apb_wr(addr_of(3), 32'h8000_000A);
    apb_wr(addr_of(4), 32'hFF);
    apb_wr(addr_of(2), 32'h0003_0708);
    apb_wr(addr_of(0), 32'd1);
    apb_wr(addr_of(0), 32'd0);
    apb_rd("time_mask0", addr_of(2), 32'h0003_070A);
    apb_rd("evt_mask0",  addr_of(4), 32'h0);
    apb_wr(addr_of(3), 32'h8100_000A);
    apb_wr(addr_of(4), 32'hFF);
    apb_wr(addr_of(2), 32'h0000_000A);
    apb_rd("evt_alarm_on_write", addr_of(4), 32'h1);
    apb_wr(addr_of(2), 32'h001F_3F3F);
    apb_rd("time_clamp", addr_of(2), 32'h0017_3B3B);

    // Error / silently-ignored accesses.
    apb_rd("rd_unmapped", 12'h03C, 32'h0);
    chk("err_unmapped", last_err, EXP_ERR);
    apb_wr(addr_of(9), 32'h1234);
    chk("err_tval_wr", last_err, EXP_ERR);
    apb_rd("tval0_ro", addr_of(9), 32'h0);
    apb_wr(12'h001, 32'd1);
    chk("err_misalign", last_err, EXP_ERR);
    apb_rd("ctrl_misalign", addr_of(0), 32'h0);
    chk("err_none", last_err, 0);

    // Reset during a PRESC write access phase: write dropped, reset values back.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr_of(1); pwdata = 32'd5;
    @(posedge pclk); #1 penable = 1'b1; prst = 1'b1;
    @(posedge pclk); #1 psel = 1'b0; penable = 1'b0; prst = 1'b0;
    apb_rd("presc_after_rst", addr_of(1), 32'h0000_7FFF);
    apb_rd("time_after_rst",  addr_of(2), 32'h0);
    apb_rd("alarm_after_rst", addr_of(3), 32'h0);
    chk("irq_after_rst", irq_o, 0);

    idle(2);
    chk("rdq_empty", 32'(eq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
